axis_frame_length_adjust: RTL and testbench
===========================================

AXIS_FRAME_LENGTH_ADJUST -- requirements
Module: axis_frame_length_adjust

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: tdata width; one beat carries one length unit.
REQ-002 SHALL have parameter ID_WIDTH, default 8: tid width.
REQ-003 SHALL have parameter DEST_WIDTH, default 8: tdest width.
REQ-004 SHALL have parameter USER_WIDTH, default 1: tuser width; bit 0 is the bad-frame flag.
REQ-005 SHALL have parameter LEN_WIDTH, default 16: width of length inputs, counters and status fields.
REQ-006 SHALL have ports, in this order: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have s_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser: input stream; tready is an output, all others inputs; widths as parameters.
REQ-008 SHALL have m_axis_tdata/tvalid/tready/tlast/tid/tdest/tuser: output stream; tready is an input, all others outputs; widths as parameters.
REQ-009 SHALL have length_min in LEN_WIDTH: minimum frame length in beats; values 0 and 1 disable padding.
REQ-010 SHALL have length_max in LEN_WIDTH: maximum frame length in beats; value 0 means unlimited.
REQ-011 SHALL have status_valid out 1, one-cycle frame-done pulse; status_frame_pad out 1; status_frame_truncate out 1; status_frame_length out LEN_WIDTH, beats emitted; status_frame_original_length out LEN_WIDTH, beats received, saturating.

Function
REQ-012 SHALL register all m_axis outputs; input-to-output latency is exactly 1 cycle.
REQ-013 SHALL use states TRANSFER, PAD, DROP; it leaves reset in TRANSFER.
REQ-014 SHALL drive s_axis_tready = (state==TRANSFER && (!m_axis_tvalid || m_axis_tready)) || state==DROP.
REQ-015 SHALL, in TRANSFER, forward every accepted beat unchanged and increment the output count.
REQ-016 SHALL, on an accepted tlast beat with out_count+1 < length_min, emit that beat with tlast=0 and enter PAD.
REQ-017 SHALL, in PAD, emit beats with tdata=0 and tid/tdest/tuser held from the last input beat; the beat bringing the count to length_min carries tlast=1 and returns to TRANSFER.
REQ-018 SHALL, on an accepted non-last beat with length_max!=0 and out_count+1 == length_max, emit that beat with tlast=1 and enter DROP.
REQ-019 SHALL, in DROP, accept and discard beats; the accepted tlast beat returns to TRANSFER with counters cleared.
REQ-020 SHALL give truncation priority over padding when length_min > length_max.
REQ-021 SHALL sample length_min and length_max on the first beat of each frame and hold them for the whole frame.
REQ-022 SHALL pulse status_valid for 1 cycle after the cycle in which the later of two events completes: output tlast transferred, or input tlast accepted. Status fields SHALL hold until the next pulse.
REQ-023 SHALL never drop or duplicate a beat in TRANSFER while m_axis_tready toggles every cycle.

Reset
REQ-024 SHALL, on rst, force m_axis_tvalid=0, state=TRANSFER, counters=0, status_valid=0, status fields=0.
REQ-025 SHALL, on rst mid-frame, abandon the frame; the first beat accepted after reset starts a new frame.
REQ-026 SHALL not reset the data, tid, tdest or tuser registers.

Configuration
REQ-027 SHALL, with AXIS_FLA_TRUNC_MARK_BAD_EN defined, force tuser[0]=1 on the tlast beat of a truncated frame, so the downstream frame FIFO drops it as a bad frame.
REQ-028 SHALL, without AXIS_FLA_TRUNC_MARK_BAD_EN, pass tuser unchanged on truncation.

Structure
REQ-029 SHALL take the state enum and default LEN_WIDTH from shared package axis_fla_pkg.
REQ-030 SHALL place the output register and its handshake in a single sub-module, axis_fla_out_reg; the FSM and counters stay in the top module.

Verification
REQ-031 SHALL cover: length_min=4, length_max=0, 2-beat frame 0xA1,0xA2 -> output A1,A2,00,00 with tlast on beat 4; status pad=1, length=4, original=2.
REQ-032 SHALL cover: length_max=3, 6-beat frame -> 3 beats out with tlast on beat 3; s_axis_tready stays 1 for beats 4-6; status truncate=1, length=3, original=6.
REQ-033 SHALL cover: the REQ-032 stimulus with AXIS_FLA_TRUNC_MARK_BAD_EN defined -> tuser[0]=1 on output beat 3 only.
REQ-034 SHALL cover: length_min=2, length_max=8, 5-beat frame with m_axis_tready toggling 1/0 -> 5 beats identical to input, no loss, status pad=0, truncate=0.
REQ-035 SHALL cover: rst asserted during PAD after 1 pad beat -> next cycle m_axis_tvalid=0 and state TRANSFER; the following 1-beat frame with length_min=0 passes unaltered.
REQ-036 SHALL cover: length_min=5, length_max=3, 1-beat frame -> truncation wins per REQ-020; output is 1 beat with tlast=1, status pad=0.

Source files
------------

// File: rtl/axis_fla_pkg.sv
// Shared types and defaults for the AXI-Stream frame length adjuster.
package axis_fla_pkg;

  localparam int unsigned LEN_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    TRANSFER = 2'd0,
    PAD      = 2'd1,
    DROP     = 2'd2
  } fla_state_t;

endpackage

// File: rtl/axis_fla_out_reg.sv
// Registered AXI-Stream output stage: one beat of storage, loaded by the
// frame length FSM whenever ready is high.
module axis_fla_out_reg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_tdata,
  input  logic                  ld_tlast,
  input  logic [ID_WIDTH-1:0]   ld_tid,
  input  logic [DEST_WIDTH-1:0] ld_tdest,
  input  logic [USER_WIDTH-1:0] ld_tuser,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  assign ready = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Payload registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (load) begin
      m_axis_tdata <= ld_tdata;
      m_axis_tlast <= ld_tlast;
      m_axis_tid   <= ld_tid;
      m_axis_tdest <= ld_tdest;
      m_axis_tuser <= ld_tuser;
    end
  end

endmodule

// File: rtl/axis_frame_length_adjust.sv
// Pads short frames with zero beats and truncates long ones.
// Define AXIS_FLA_TRUNC_MARK_BAD_EN to set tuser[0] on the last beat of a truncated frame.
module axis_frame_length_adjust
  import axis_fla_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  status_valid,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic [LEN_WIDTH-1:0]  status_frame_length,
  output logic [LEN_WIDTH-1:0]  status_frame_original_length
);

  fla_state_t state, state_n;
  logic [LEN_WIDTH-1:0]  out_count, out_n, in_count, in_n, in_inc;
  logic [LEN_WIDTH:0]    out_inc;
  logic [LEN_WIDTH-1:0]  len_min_r, len_max_r, cur_min, cur_max, pad_min;
  logic [LEN_WIDTH-1:0]  snap_len, snap_orig;
  logic                  frame_pad, frame_trunc, pad_n, trunc_n, snap_pad, snap_trunc;
  logic                  in_done, out_done, in_now, out_now, frame_end;
  logic                  s_fire, first_beat, out_ready, out_evt, load;
  logic [DATA_WIDTH-1:0] ld_tdata;
  logic                  ld_tlast;
  logic [ID_WIDTH-1:0]   ld_tid, hold_tid;
  logic [DEST_WIDTH-1:0] ld_tdest, hold_tdest;
  logic [USER_WIDTH-1:0] ld_tuser, hold_tuser;

  assign s_axis_tready = (state == TRANSFER && out_ready) || state == DROP;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign first_beat    = (in_count == '0);
  assign cur_min       = first_beat ? length_min : len_min_r;
  assign cur_max       = first_beat ? length_max : len_max_r;
  // Truncation wins: an unreachable minimum disables padding altogether.
  assign pad_min       = (cur_max != '0 && cur_min > cur_max) ? '0 : cur_min;
  assign out_inc       = {1'b0, out_count} + (LEN_WIDTH+1)'(1);
  assign in_inc        = (in_count == '1) ? in_count : in_count + LEN_WIDTH'(1);
  assign out_evt       = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    state_n   = state;
    out_n     = out_count;
    in_n      = in_count;
    pad_n     = frame_pad;
    trunc_n   = frame_trunc;
    frame_end = 1'b0;
    load      = 1'b0;
    ld_tdata  = s_axis_tdata;
    ld_tlast  = s_axis_tlast;
    ld_tid    = s_axis_tid;
    ld_tdest  = s_axis_tdest;
    ld_tuser  = s_axis_tuser;
    case (state)
      TRANSFER: begin
        if (s_fire) begin
          load  = 1'b1;
          out_n = out_inc[LEN_WIDTH-1:0];
          in_n  = in_inc;
          if (!s_axis_tlast && cur_max != '0 && out_inc == {1'b0, cur_max}) begin
            ld_tlast = 1'b1;
            trunc_n  = 1'b1;
            state_n  = DROP;
`ifdef AXIS_FLA_TRUNC_MARK_BAD_EN
            ld_tuser[0] = 1'b1;
`endif
          end else if (s_axis_tlast && out_inc < {1'b0, pad_min}) begin
            ld_tlast = 1'b0;
            pad_n    = 1'b1;
            state_n  = PAD;
          end else if (s_axis_tlast) begin
            frame_end = 1'b1;
          end
        end
      end
      PAD: begin
        if (out_ready) begin
          load     = 1'b1;
          ld_tdata = '0;
          ld_tid   = hold_tid;
          ld_tdest = hold_tdest;
          ld_tuser = hold_tuser;
          out_n    = out_inc[LEN_WIDTH-1:0];
          ld_tlast = (out_inc >= {1'b0, len_min_r});
          if (ld_tlast) begin
            frame_end = 1'b1;
            state_n   = TRANSFER;
          end
        end
      end
      DROP: begin
        if (s_fire) begin
          in_n = in_inc;
          if (s_axis_tlast) begin
            frame_end = 1'b1;
            state_n   = TRANSFER;
          end
        end
      end
      default: state_n = TRANSFER;
    endcase
  end

  // Status fires once both the input side has closed the frame and the
  // output tlast has been transferred, whichever comes last.
  assign in_now  = in_done || frame_end;
  assign out_now = out_done || out_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                        <= TRANSFER;
      out_count                    <= '0;
      in_count                     <= '0;
      frame_pad                    <= 1'b0;
      frame_trunc                  <= 1'b0;
      len_min_r                    <= '0;
      len_max_r                    <= '0;
      snap_len                     <= '0;
      snap_orig                    <= '0;
      snap_pad                     <= 1'b0;
      snap_trunc                   <= 1'b0;
      in_done                      <= 1'b0;
      out_done                     <= 1'b0;
      status_valid                 <= 1'b0;
      status_frame_pad             <= 1'b0;
      status_frame_truncate        <= 1'b0;
      status_frame_length          <= '0;
      status_frame_original_length <= '0;
    end else begin
      state <= state_n;
      if (state == TRANSFER && s_fire && first_beat) begin
        len_min_r <= length_min;
        len_max_r <= length_max;
      end
      if (frame_end) begin
        out_count   <= '0;
        in_count    <= '0;
        frame_pad   <= 1'b0;
        frame_trunc <= 1'b0;
        snap_len    <= out_n;
        snap_orig   <= in_n;
        snap_pad    <= frame_pad;
        snap_trunc  <= frame_trunc;
      end else begin
        out_count   <= out_n;
        in_count    <= in_n;
        frame_pad   <= pad_n;
        frame_trunc <= trunc_n;
      end
      if (in_now && out_now) begin
        status_valid                 <= 1'b1;
        status_frame_pad             <= frame_end ? frame_pad   : snap_pad;
        status_frame_truncate        <= frame_end ? frame_trunc : snap_trunc;
        status_frame_length          <= frame_end ? out_n       : snap_len;
        status_frame_original_length <= frame_end ? in_n        : snap_orig;
        in_done                      <= 1'b0;
        out_done                     <= 1'b0;
      end else begin
        status_valid <= 1'b0;
        in_done      <= in_now;
        out_done     <= out_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == TRANSFER && s_fire) begin
      hold_tid   <= s_axis_tid;
      hold_tdest <= s_axis_tdest;
      hold_tuser <= s_axis_tuser;
    end
  end

  axis_fla_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .DEST_WIDTH (DEST_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .ld_tdata      (ld_tdata),
    .ld_tlast      (ld_tlast),
    .ld_tid        (ld_tid),
    .ld_tdest      (ld_tdest),
    .ld_tuser      (ld_tuser),
    .ready         (out_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser)
  );

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Directed self-checking bench for axis_frame_length_adjust (default parameters).
module tb_axis_frame_length_adjust;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tid = '0;
  logic [7:0]  s_axis_tdest = 8'h66;
  logic [0:0]  s_axis_tuser = '0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [15:0] length_min = '0;
  logic [15:0] length_max = '0;
  logic        status_valid;
  logic        status_frame_pad;
  logic        status_frame_truncate;
  logic [15:0] status_frame_length;
  logic [15:0] status_frame_original_length;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned st_n   = 0;
  logic        st_pad, st_trunc;
  logic [15:0] st_len, st_orig;
  logic        toggle_en = 1'b0;
  logic [17:0] out_q[$];
  logic        mark_bad;

  axis_frame_length_adjust dut (
    .clk                          (clk),
    .rst                          (rst),
    .s_axis_tdata                 (s_axis_tdata),
    .s_axis_tvalid                (s_axis_tvalid),
    .s_axis_tready                (s_axis_tready),
    .s_axis_tlast                 (s_axis_tlast),
    .s_axis_tid                   (s_axis_tid),
    .s_axis_tdest                 (s_axis_tdest),
    .s_axis_tuser                 (s_axis_tuser),
    .m_axis_tdata                 (m_axis_tdata),
    .m_axis_tvalid                (m_axis_tvalid),
    .m_axis_tready                (m_axis_tready),
    .m_axis_tlast                 (m_axis_tlast),
    .m_axis_tid                   (m_axis_tid),
    .m_axis_tdest                 (m_axis_tdest),
    .m_axis_tuser                 (m_axis_tuser),
    .length_min                   (length_min),
    .length_max                   (length_max),
    .status_valid                 (status_valid),
    .status_frame_pad             (status_frame_pad),
    .status_frame_truncate        (status_frame_truncate),
    .status_frame_length          (status_frame_length),
    .status_frame_original_length (status_frame_original_length)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
  end

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back({m_axis_tid, m_axis_tuser[0], m_axis_tlast, m_axis_tdata});
    if (status_valid) begin
      st_n++;
      st_pad   = status_frame_pad;
      st_trunc = status_frame_truncate;
      st_len   = status_frame_length;
      st_orig  = status_frame_original_length;
    end
  end

  function automatic logic [17:0] beat(input logic [7:0] tid, input logic u,
                                       input logic l, input logic [7:0] d);
    return {tid, u, l, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int unsigned idx, input logic [17:0] exp);
    logic [17:0] obs;
    obs = (idx < out_q.size()) ? out_q[idx] : 18'h3ffff;
    check(tag, {14'd0, obs}, {14'd0, exp});
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u,
                           input logic [7:0] tid, output int unsigned waits);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tid    = tid;
    s_axis_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready || waits >= 50) break;
      waits++;
    end
    check("accept_timeout", {31'd0, waits < 50}, 32'd1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_status(input int unsigned exp_n);
    int unsigned n = 0;
    while (st_n < exp_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("status_timeout", st_n, exp_n);
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic pad, input logic trunc,
                              input logic [15:0] len, input logic [15:0] orig);
    check({tag, "_pad"},   {31'd0, st_pad},   {31'd0, pad});
    check({tag, "_trunc"}, {31'd0, st_trunc}, {31'd0, trunc});
    check({tag, "_len"},   {16'd0, st_len},   {16'd0, len});
    check({tag, "_orig"},  {16'd0, st_orig},  {16'd0, orig});
  endtask

  initial begin
    int unsigned w;
`ifdef AXIS_FLA_TRUNC_MARK_BAD_EN
    mark_bad = 1'b1;
`else
    mark_bad = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_status_valid", {31'd0, status_valid}, 32'd0);
    check("rst_status_len", {16'd0, status_frame_length}, 32'd0);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    rst = 1'b0;

    // Padding: 2-beat frame padded to 4
    length_min = 16'd4; length_max = 16'd0;
    send_beat(8'hA1, 1'b0, 1'b0, 8'h11, w);
    send_beat(8'hA2, 1'b1, 1'b1, 8'h11, w);
    wait_status(1);
    check("pad_count", out_q.size(), 4);
    check_beat("pad_b0", 0, beat(8'h11, 1'b0, 1'b0, 8'hA1));
    check_beat("pad_b1", 1, beat(8'h11, 1'b1, 1'b0, 8'hA2));
    check_beat("pad_b2", 2, beat(8'h11, 1'b1, 1'b0, 8'h00));
    check_beat("pad_b3", 3, beat(8'h11, 1'b1, 1'b1, 8'h00));
    check_status("pad_st", 1'b1, 1'b0, 16'd4, 16'd2);
    out_q.delete();

    // Truncation: 6-beat frame cut to 3
    length_min = 16'd0; length_max = 16'd3;
    for (int i = 1; i <= 6; i++) begin
      send_beat(8'hB0 + 8'(i), (i == 6), 1'b0, 8'h22, w);
      if (i >= 4) check("trunc_drop_tready", w, 0);
    end
    wait_status(2);
    check("trunc_count", out_q.size(), 3);
    check_beat("trunc_b0", 0, beat(8'h22, 1'b0, 1'b0, 8'hB1));
    check_beat("trunc_b1", 1, beat(8'h22, 1'b0, 1'b0, 8'hB2));
    check_beat("trunc_b2", 2, beat(8'h22, mark_bad, 1'b1, 8'hB3));
    check_status("trunc_st", 1'b0, 1'b1, 16'd3, 16'd6);
    out_q.delete();

    // Pass-through with m_axis_tready toggling
    length_min = 16'd2; length_max = 16'd8;
    toggle_en = 1'b1;
    for (int i = 1; i <= 5; i++)
      send_beat(8'hC0 + 8'(i), (i == 5), 1'(i % 2), 8'h30 + 8'(i), w);
    wait_status(3);
    toggle_en = 1'b0;
    check("tog_count", out_q.size(), 5);
    for (int i = 1; i <= 5; i++)
      check_beat("tog_beat", i - 1, beat(8'h30 + 8'(i), 1'(i % 2), (i == 5), 8'hC0 + 8'(i)));
    check_status("tog_st", 1'b0, 1'b0, 16'd5, 16'd5);
    out_q.delete();

    // Reset during PAD after one pad beat
    length_min = 16'd4; length_max = 16'd0;
    send_beat(8'hD1, 1'b1, 1'b0, 8'h44, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("prst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("prst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check("prst_count", out_q.size(), 2);
    check_beat("prst_b0", 0, beat(8'h44, 1'b0, 1'b0, 8'hD1));
    check_beat("prst_b1", 1, beat(8'h44, 1'b0, 1'b0, 8'h00));
    out_q.delete();
    length_min = 16'd0;
    send_beat(8'hE1, 1'b1, 1'b0, 8'h55, w);
    wait_status(4);
    check("post_count", out_q.size(), 1);
    check_beat("post_b0", 0, beat(8'h55, 1'b0, 1'b1, 8'hE1));
    check_status("post_st", 1'b0, 1'b0, 16'd1, 16'd1);
    out_q.delete();

    // min > max: truncation priority suppresses padding
    length_min = 16'd5; length_max = 16'd3;
    send_beat(8'hF1, 1'b1, 1'b0, 8'h66, w);
    wait_status(5);
    check("prio_count", out_q.size(), 1);
    check_beat("prio_b0", 0, beat(8'h66, 1'b0, 1'b1, 8'hF1));
    check_status("prio_st", 1'b0, 1'b0, 16'd1, 16'd1);

    repeat (5) @(posedge clk);
    #1;
    check("status_pulses", st_n, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
